sgpr_regfile: RTL and testbench



---
 rtl/sgpr_pkg.sv | 11 +
 rtl/sgpr_regfile_if.sv | 24 ++
 rtl/sgpr_wdec.sv | 17 +
 rtl/sgpr_regfile.sv | 48 ++++
 tb/tb_sgpr_regfile.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/sgpr_pkg.sv
// Shared widths and types for the general-purpose register file.
package sgpr_pkg;

  localparam int SGPR_ADDR_WIDTH = 5;
  localparam int SGPR_DATA_WIDTH = 32;
  localparam int SGPR_NUM_WORDS  = 32;

  typedef logic [SGPR_ADDR_WIDTH-1:0] sgpr_addr_t;
  typedef logic [SGPR_DATA_WIDTH-1:0] sgpr_data_t;

endpackage

// File: rtl/sgpr_regfile_if.sv
// Operand read / writeback bus between the core and the register file.
interface sgpr_regfile_if;
  import sgpr_pkg::*;

  logic       test_en_i;
  sgpr_addr_t raddr_a_i;
  sgpr_data_t rdata_a_o;
  sgpr_addr_t raddr_b_i;
  sgpr_data_t rdata_b_o;
  sgpr_addr_t waddr_a_i;
  sgpr_data_t wdata_a_i;
  logic       we_a_i;

  modport master (
    output test_en_i, raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i,
    input  rdata_a_o, rdata_b_o
  );

  modport slave (
    input  test_en_i, raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i,
    output rdata_a_o, rdata_b_o
  );

endinterface

// File: rtl/sgpr_wdec.sv
// One-hot write decoder; word 0 has no storage so its enable never fires.
module sgpr_wdec
  import sgpr_pkg::*;
(
  input  sgpr_addr_t                i_waddr,
  input  logic                      i_we,
  output logic [SGPR_NUM_WORDS-1:0] o_wen
);

  always_comb begin
    o_wen = '0;
    if (i_we && (i_waddr != '0)) begin
      o_wen[i_waddr] = 1'b1;
    end
  end

endmodule

// File: rtl/sgpr_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// word 0 hard-wired to zero.
module sgpr_regfile
  import sgpr_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  sgpr_regfile_if.slave  bus
);

  sgpr_data_t                r_mem [1:SGPR_NUM_WORDS-1];
  sgpr_data_t                w_word [SGPR_NUM_WORDS];
  logic [SGPR_NUM_WORDS-1:0] w_wen;
  logic                      w_unused_test_en;

  // test_en_i only matters for a latch-based variant; flops ignore it.
  assign w_unused_test_en = bus.test_en_i;

  sgpr_wdec u_wdec (
    .i_waddr (bus.waddr_a_i),
    .i_we    (bus.we_a_i),
    .o_wen   (w_wen)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < SGPR_NUM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < SGPR_NUM_WORDS; i++) begin
        if (w_wen[i]) begin
          r_mem[i] <= bus.wdata_a_i;
        end
      end
    end
  end

  assign w_word[0] = '0;
  for (genvar g = 1; g < SGPR_NUM_WORDS; g++) begin : g_word
    assign w_word[g] = r_mem[g];
  end

  // No write bypass: a same-cycle read sees the pre-edge contents.
  assign bus.rdata_a_o = w_word[bus.raddr_a_i];
  assign bus.rdata_b_o = w_word[bus.raddr_b_i];

endmodule

// File: tb/tb_sgpr_regfile.sv
// Directed plus randomized checks of sgpr_regfile against an array model.
module tb_sgpr_regfile;
  import sgpr_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #50 clk = ~clk;

  sgpr_regfile_if bus ();
  sgpr_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [31:0] model [32];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reads(input string tag);
    chk({tag, "_a"}, bus.rdata_a_o, model[bus.raddr_a_i]);
    chk({tag, "_b"}, bus.rdata_b_o, model[bus.raddr_b_i]);
  endtask

  // Present one write at the falling edge, apply it to the model at the rising edge.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    bus.we_a_i    = we;
    bus.waddr_a_i = wa;
    bus.wdata_a_i = wd;
    @(posedge clk);
    if (rst_n && we && wa != 5'd0) model[wa] = wd;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    bus.test_en_i = 1'b0;
    bus.raddr_a_i = 5'd10;
    bus.raddr_b_i = 5'd0;
    bus.we_a_i    = 1'b1;
    bus.waddr_a_i = 5'd10;
    bus.wdata_a_i = 32'd100;

    // Reset held with a write pending: nothing lands.
    @(posedge clk); #1;
    chk("rst_word10", bus.rdata_a_o, 32'd0);
    @(posedge clk); #1;
    chk("rst_word10_2", bus.rdata_a_o, 32'd0);
    @(negedge clk);
    bus.we_a_i = 1'b0;
    rst_n      = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_word10", bus.rdata_a_o, 32'd0);

    // Fill and sweep.
    for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'(i));
    cyc(1'b0, 5'd0, 32'd0);
    for (int j = 1; j < 32; j++) begin
      bus.raddr_a_i = 5'(j);
      bus.raddr_b_i = 5'(j);
      #1;
      chk("fill_a", bus.rdata_a_o, 32'(j));
      chk("fill_b", bus.rdata_b_o, 32'(j));
    end

    // Register zero ignores writes.
    bus.raddr_a_i = 5'd0;
    bus.raddr_b_i = 5'd0;
    #1;
    chk("zero_pre_a", bus.rdata_a_o, 32'd0);
    chk("zero_pre_b", bus.rdata_b_o, 32'd0);
    cyc(1'b1, 5'd0, 32'hDEADBEEF);
    chk("zero_post_a", bus.rdata_a_o, 32'd0);
    chk("zero_post_b", bus.rdata_b_o, 32'd0);

    // Write enable low.
    bus.raddr_a_i = 5'd5;
    cyc(1'b0, 5'd5, 32'hFFFFFFFF);
    chk("we_low_word5", bus.rdata_a_o, 32'd5);

    // Read-during-write: old value before the edge, new after, port B untouched.
    @(negedge clk);
    bus.raddr_a_i = 5'd7;
    bus.raddr_b_i = 5'd8;
    bus.we_a_i    = 1'b1;
    bus.waddr_a_i = 5'd7;
    bus.wdata_a_i = 32'h12345678;
    #1;
    chk("rdw_before", bus.rdata_a_o, 32'd7);
    chk("rdw_b_before", bus.rdata_b_o, 32'd8);
    @(posedge clk);
    model[7] = 32'h12345678;
    #1;
    chk("rdw_after", bus.rdata_a_o, 32'h12345678);
    chk("rdw_b_after", bus.rdata_b_o, 32'd8);
    cyc(1'b0, 5'd0, 32'd0);

    // Randomized traffic with test_en_i toggling.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.test_en_i = 1'($urandom);
      bus.raddr_a_i = 5'($urandom);
      bus.raddr_b_i = ($urandom_range(0, 3) == 0) ? bus.raddr_a_i : 5'($urandom);
      bus.we_a_i    = 1'($urandom);
      bus.waddr_a_i = ($urandom_range(0, 3) == 0) ? bus.raddr_a_i : 5'($urandom);
      bus.wdata_a_i = $urandom;
      #1;
      chk_reads("rnd_pre");
      @(posedge clk);
      if (bus.we_a_i && bus.waddr_a_i != 5'd0) model[bus.waddr_a_i] = bus.wdata_a_i;
      #1;
      chk_reads("rnd_post");
    end

    // Asynchronous reset between edges: every word reads zero before the next edge.
    @(negedge clk);
    bus.we_a_i = 1'b0;
    bus.test_en_i = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    for (int j = 0; j < 32; j++) begin
      bus.raddr_a_i = 5'(j);
      bus.raddr_b_i = 5'(31 - j);
      #1;
      chk("async_rst_a", bus.rdata_a_o, 32'd0);
      chk("async_rst_b", bus.rdata_b_o, 32'd0);
    end
    chk("async_rst_before_edge", {31'd0, clk}, 32'd1);

    // Write presented across reset release lands on the first edge with rst_n high.
    @(negedge clk);
    bus.we_a_i    = 1'b1;
    bus.waddr_a_i = 5'd3;
    bus.wdata_a_i = 32'hA5A5_0003;
    bus.raddr_a_i = 5'd3;
    bus.raddr_b_i = 5'd4;
    rst_n = 1'b1;
    @(posedge clk);
    model[3] = 32'hA5A5_0003;
    #1;
    chk("rel_write_a", bus.rdata_a_o, 32'hA5A5_0003);
    chk("rel_write_b", bus.rdata_b_o, 32'd0);
    cyc(1'b0, 5'd0, 32'd0);
    chk_reads("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
